// File: rtl/alu_pkg.sv
// Shared constants, select encodings and state type for the ALU operand stage.
// Forwarding is enabled by defining ALU_OPERAND_FWD_EN.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int SEL_W   = 3;
    localparam int SHAMT_W = 5;

    localparam logic [SEL_W-1:0] ALU_ADD  = 3'd0;
    localparam logic [SEL_W-1:0] ALU_AND  = 3'd1;
    localparam logic [SEL_W-1:0] ALU_XOR  = 3'd2;
    localparam logic [SEL_W-1:0] ALU_SLL  = 3'd3;
    localparam logic [SEL_W-1:0] ALU_SRA  = 3'd4;
    localparam logic [SEL_W-1:0] ALU_SUB  = 3'd5;
    localparam logic [SEL_W-1:0] ALU_JALR = 3'd6;
    localparam logic [SEL_W-1:0] ALU_ZERO = 3'd7;

    localparam logic [RADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } vstate_e;

    function automatic logic is_shift(input logic [SEL_W-1:0] s);
        return (s == ALU_SLL) || (s == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Single source-register forwarding selector: EX/MEM beats MEM/WB,
// and register x0 always reads the register file.
module fwd_mux
    import alu_pkg::*;
#(
    parameter int W  = XLEN,
    parameter int AW = RADDR_W
) (
    input  logic [AW-1:0] i_src,
    input  logic [W-1:0]  i_rf_data,
    input  logic          i_exm_we,
    input  logic [AW-1:0] i_exm_rd,
    input  logic [W-1:0]  i_exm_data,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_rd,
    input  logic [W-1:0]  i_wb_data,
    output logic [W-1:0]  o_data
);

    logic w_nz;
    logic w_exm_hit;
    logic w_wb_hit;

    assign w_nz      = (i_src != '0);
    assign w_exm_hit = w_nz && i_exm_we && (i_exm_rd == i_src);
    assign w_wb_hit  = w_nz && i_wb_we && (i_wb_rd == i_src);

    always_comb begin
        o_data = i_rf_data;
        if (w_exm_hit) begin
            o_data = i_exm_data;
        end else if (w_wb_hit) begin
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage feeding the ALU: forwarding, operand-B select, shift masking.
// Define ALU_OPERAND_FWD_EN to build the EX/MEM and MEM/WB forwarding muxes.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int XLEN    = alu_pkg::XLEN,
    parameter int RADDR_W = alu_pkg::RADDR_W,
    parameter int SEL_W   = alu_pkg::SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [RADDR_W-1:0] in_rs1_addr,
    input  logic [RADDR_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]    in_imm,
    input  logic               in_use_imm,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic [RADDR_W-1:0] in_rd_addr,
    input  logic               in_reg_write,
    input  logic               flush,
    input  logic               exm_reg_write,
    input  logic [RADDR_W-1:0] exm_rd_addr,
    input  logic [XLEN-1:0]    exm_result,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]    wb_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    rs1,
    output logic [XLEN-1:0]    rs2,
    output logic [SEL_W-1:0]   sel,
    output logic [RADDR_W-1:0] rd_addr,
    output logic               reg_write
);

    vstate_e            r_state;
    logic [XLEN-1:0]    r_rs1;
    logic [XLEN-1:0]    r_rs2;
    logic [SEL_W-1:0]   r_sel;
    logic [RADDR_W-1:0] r_rd_addr;
    logic               r_reg_write;

    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_rs2_fwd;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_b_final;
    logic            w_cap;

`ifdef ALU_OPERAND_FWD_EN
    fwd_mux #(.W(XLEN), .AW(RADDR_W)) u_fwd_rs1 (
        .i_src      (in_rs1_addr),
        .i_rf_data  (in_rs1_data),
        .i_exm_we   (exm_reg_write),
        .i_exm_rd   (exm_rd_addr),
        .i_exm_data (exm_result),
        .i_wb_we    (wb_reg_write),
        .i_wb_rd    (wb_rd_addr),
        .i_wb_data  (wb_result),
        .o_data     (w_a)
    );

    fwd_mux #(.W(XLEN), .AW(RADDR_W)) u_fwd_rs2 (
        .i_src      (in_rs2_addr),
        .i_rf_data  (in_rs2_data),
        .i_exm_we   (exm_reg_write),
        .i_exm_rd   (exm_rd_addr),
        .i_exm_data (exm_result),
        .i_wb_we    (wb_reg_write),
        .i_wb_rd    (wb_rd_addr),
        .i_wb_data  (wb_result),
        .o_data     (w_rs2_fwd)
    );
`else
    // Hazard unit stalls instead; bypass inputs are intentionally dead here.
    logic w_unused;
    assign w_unused  = ^{exm_reg_write, exm_rd_addr, exm_result,
                         wb_reg_write, wb_rd_addr, wb_result,
                         in_rs1_addr, in_rs2_addr};
    assign w_a       = in_rs1_data;
    assign w_rs2_fwd = in_rs2_data;
`endif

    assign w_b = in_use_imm ? in_imm : w_rs2_fwd;

    always_comb begin
        w_b_final = w_b;
        if (is_shift(in_sel)) begin
            w_b_final = {{(XLEN-SHAMT_W){1'b0}}, w_b[SHAMT_W-1:0]};
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_cap     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_sel       <= '0;
            r_rd_addr   <= '0;
            r_reg_write <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_reg_write <= 1'b0;
        end else if (w_cap) begin
            r_state     <= ST_FULL;
            r_rs1       <= w_a;
            r_rs2       <= w_b_final;
            r_sel       <= in_sel;
            r_rd_addr   <= in_rd_addr;
            r_reg_write <= in_reg_write;
        end else if (out_valid && out_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign sel       = r_sel;
    assign rd_addr   = r_rd_addr;
    assign reg_write = r_reg_write;

endmodule
